instruction_loader: RTL
=======================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clock  in  1  system clock, all state on rising edge; reset  in  1  asynchronous active-low reset.
REQ-002 start  in  1  one-cycle request to begin a load session.
REQ-003 rx_data  in  8  incoming program byte.
REQ-004 rx_valid  in  1  rx_data valid.
REQ-005 rx_ready  out  1  loader can accept a byte; a byte transfers on a clock edge where rx_valid && rx_ready.
REQ-006 mem_we  out  1  instruction-memory write enable.
REQ-007 mem_addr  out  9  instruction-memory word address (byte address [10:2]).
REQ-008 mem_wdata  out  32  instruction word to write.
REQ-009 cpu_hold  out  1  holds the CPU in reset while high.
REQ-010 busy  out  1  load session in progress.
REQ-011 done  out  1  last session completed successfully (level).
REQ-012 error  out  1  last session rejected (level).
REQ-013 words_loaded  out  10  words written in the current or last session.

Function
REQ-014 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-015 IDLE, DONE and ERR SHALL move to LEN_LO on start; they SHALL clear done, error and words_loaded on that edge; start SHALL be ignored in every other state.
REQ-016 rx_ready SHALL be 1 only in LEN_LO, LEN_HI and DATA.
REQ-017 Header: the first accepted byte SHALL be len[7:0] and the second len[15:8]; len is the word count.
REQ-018 After LEN_HI: len==0 -> DONE; len>512 -> ERR; otherwise -> DATA, with word index 0 and byte counter 0.
REQ-019 DATA SHALL assemble bytes little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-020 On acceptance of the fourth byte the FSM SHALL move to WRITE.
REQ-021 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr = word index and mem_wdata = the assembled word. The write occurs on the clock edge after the fourth byte is accepted.
REQ-022 At the end of WRITE the block SHALL increment the word index and words_loaded; it SHALL go to DONE if index==len, else to DATA.
REQ-023 mem_we SHALL be 0 in every state except WRITE.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-025 Peak throughput SHALL be one word per 5 cycles; rx_valid gaps SHALL stall without losing partial words.
REQ-026 busy SHALL be 1 in LEN_LO, LEN_HI, DATA and WRITE.
REQ-027 cpu_hold SHALL be 1 in every state except DONE.
REQ-028 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR.
REQ-029 The word index SHALL never exceed 511, and words_loaded SHALL never exceed 512.

Reset
REQ-030 Asserting reset (reset=0) SHALL force IDLE immediately, independent of clock.
REQ-031 On reset: cpu_hold=1; busy, done, error, rx_ready and mem_we=0; mem_addr=0, mem_wdata=0 and words_loaded=0.
REQ-032 Reset mid-session SHALL discard any partial word with no write; memory already written SHALL NOT be cleared.
REQ-033 Reset release SHALL take effect on the next rising clock edge.

Verification
REQ-034 Reset: hold reset=0 mid-DATA -> all outputs at REQ-031 values without a clock edge; cpu_hold=1.
REQ-035 Two-word load: start, then bytes 02 00 78 56 34 12 EF BE AD DE -> mem_we pulses with addr 0 / 0x12345678 and addr 1 / 0xDEADBEEF; then done=1, cpu_hold=0, words_loaded=2.
REQ-036 Zero length: start, then bytes 00 00 -> DONE on the next cycle, no mem_we, words_loaded=0.
REQ-037 Oversize: start, then bytes 01 02 (len=513) -> error=1, rx_ready=0, cpu_hold=1, no writes; a later start clears error.
REQ-038 Stall and abort: rx_valid gaps of 3 cycles between bytes -> same words as with no gaps; separately, reset after 2 data bytes -> no write, and IDLE on release.
REQ-039 Full memory: len=512 (00 02) with 2048 bytes -> last write at mem_addr 511, words_loaded=512, done=1.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader
//   Receives a program image over a byte stream and writes it, one 32-bit
//   word at a time, into instruction memory while holding the CPU in reset.
//   Stream format: len[7:0], len[15:8] (word count), then 4*len data bytes,
//   each word little-endian. len == 0 finishes at once; len > 512 is rejected.
//
// Ports
//   clock        in   system clock, all state on rising edge
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle request to begin a load session
//   rx_data      in   incoming program byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader can accept a byte (transfer on rx_valid && rx_ready)
//   mem_we       out  instruction-memory write enable (one cycle per word)
//   mem_addr     out  instruction-memory word address
//   mem_wdata    out  instruction word to write
//   cpu_hold     out  holds the CPU in reset while high
//   busy         out  load session in progress
//   done         out  last session completed successfully (level)
//   error        out  last session rejected (level)
//   words_loaded out  words written in the current or last session
module instruction_loader (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [8:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [9:0]  words_loaded
);

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
   } state_t;

   state_t      state;
   state_t      nxt;
   logic [7:0]  len_lo;
   logic [9:0]  len_q;
   logic [8:0]  word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic        accept;
   logic [15:0] full_len;

   assign accept   = rx_valid & rx_ready;
   assign full_len = {rx_data, len_lo};

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) nxt = LEN_LO;
         LEN_LO:          if (accept) nxt = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if (full_len == 16'd0)
                  nxt = DONE;
               else if (full_len > 16'd512)
                  nxt = ERR;
               else
                  nxt = DATA;
            end
         end
         DATA:            if (accept && byte_cnt == 2'd3) nxt = WRITE;
         WRITE:           nxt = (words_loaded + 10'd1 == len_q) ? DONE : DATA;
         default:         nxt = IDLE;
      endcase
   end

   // Status outputs are registered by decoding the next state, so they
   // change on the same edge as the state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         rx_ready     <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_hold     <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         len_lo       <= '0;
         len_q        <= '0;
         word_idx     <= '0;
         byte_cnt     <= '0;
         word_buf     <= '0;
      end else begin
         state    <= nxt;
         rx_ready <= (nxt == LEN_LO) || (nxt == LEN_HI) || (nxt == DATA);
         busy     <= (nxt == LEN_LO) || (nxt == LEN_HI) || (nxt == DATA) || (nxt == WRITE);
         mem_we   <= (nxt == WRITE);
         cpu_hold <= (nxt != DONE);
         done     <= (nxt == DONE);
         error    <= (nxt == ERR);

         case (state)
            IDLE, DONE, ERR: begin
               if (start) words_loaded <= '0;
            end
            LEN_LO: begin
               if (accept) len_lo <= rx_data;
            end
            LEN_HI: begin
               if (accept) begin
                  len_q    <= full_len[9:0];
                  word_idx <= '0;
                  byte_cnt <= '0;
               end
            end
            DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= rx_data;
                     2'd1: word_buf[15:8]  <= rx_data;
                     2'd2: word_buf[23:16] <= rx_data;
                     default: begin
                        mem_addr  <= word_idx;
                        mem_wdata <= {rx_data, word_buf};
                     end
                  endcase
               end
            end
            WRITE: begin
               words_loaded <= words_loaded + 10'd1;
               // Index stays put on the final word so it never passes 511.
               if (nxt == DATA) word_idx <= word_idx + 9'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
